// File: rtl/fetch_unit.sv
// fetch_unit: dual-issue instruction fetch front end.
// Issues a pair of word reads (fpc, fpc+4) to a synchronous dual-read
// instruction memory with one cycle of read latency. Returned words are
// queued with their PCs in a circular fetch queue. Decode can take up to
// two queued instructions per cycle. A redirect flushes the queue and any
// read still in flight, then fetching restarts from the redirect PC.
// Optional build macro: FETCH_PERF_EN adds fetch/stall/flush event counters.
module fetch_unit #(
    parameter int          QDEPTH   = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [12:0]              imem_addr1,
    output logic [12:0]              imem_addr2,
    input  logic [31:0]              imem_ir1,
    input  logic [31:0]              imem_ir2,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    input  logic [1:0]               deq_count,
    output logic                     out_valid1,
    output logic                     out_valid2,
    output logic [31:0]              out_ir1,
    output logic [31:0]              out_ir2,
    output logic [31:0]              out_pc1,
    output logic [31:0]              out_pc2,
    output logic [$clog2(QDEPTH):0]  q_count
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]              perf_fetch_cnt,
    output logic [31:0]              perf_stall_cnt,
    output logic [31:0]              perf_flush_cnt
`endif
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    // An issue is allowed only while the queue plus the words still in flight
    // leave room for two more entries, so a capture can never overflow.
    localparam logic [CW:0] LP_ISSUE_MAX = (CW + 1)'(QDEPTH - 2);

    logic [31:0]   r_fpc;
    logic [31:0]   r_inflight_pc;
    logic          r_inflight;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic [31:0]   r_q_ir [QDEPTH];
    logic [31:0]   r_q_pc [QDEPTH];

    logic [CW:0]   w_used;
    logic          w_issue;
    logic          w_capture;
    logic [1:0]    w_deq_eff;
    logic [1:0]    w_pop;
    logic [1:0]    w_push;
    logic [AW-1:0] w_head_p1;
    logic [AW-1:0] w_tail_p1;

    assign imem_addr1 = r_fpc[14:2];
    // Adding 4 to fpc only carries from bit 2 upward, so the slot-2 index is
    // the slot-1 index plus one, wrapping at 8192 words.
    assign imem_addr2 = r_fpc[14:2] + 13'd1;

    assign w_head_p1 = r_head + AW'(1);
    assign w_tail_p1 = r_tail + AW'(1);

    // Issue credit, capture qualification and effective pop/push amounts.
    always_comb begin
        w_used    = (CW + 1)'(r_count) + (r_inflight ? (CW + 1)'(2) : (CW + 1)'(0));
        w_issue   = !redirect_valid && (w_used <= LP_ISSUE_MAX);
        w_capture = r_inflight && !redirect_valid;
        w_push    = w_capture ? 2'd2 : 2'd0;
        w_deq_eff = (deq_count == 2'd3) ? 2'd2 : deq_count;
        if (r_count < CW'(w_deq_eff)) begin
            w_pop = r_count[1:0];
        end else begin
            w_pop = w_deq_eff;
        end
    end

    // Fetch PC, in-flight tracking and queue pointers; redirect beats everything but reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fpc         <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'h0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
        end else if (redirect_valid) begin
            r_fpc      <= redirect_pc;
            r_inflight <= 1'b0;
            r_head     <= r_tail;
            r_count    <= '0;
        end else begin
            if (w_issue) begin
                r_fpc         <= r_fpc + 32'd8;
                r_inflight    <= 1'b1;
                r_inflight_pc <= r_fpc;
            end else begin
                r_inflight <= 1'b0;
            end
            r_head  <= r_head + AW'(w_pop);
            r_tail  <= r_tail + AW'(w_push);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Queue storage: the returned pair is written at tail and tail+1.
    // Contents need no reset because occupancy masks every read.
    always_ff @(posedge clk) begin
        if (rst_n && w_capture) begin
            r_q_ir[r_tail]    <= imem_ir1;
            r_q_pc[r_tail]    <= r_inflight_pc;
            r_q_ir[w_tail_p1] <= imem_ir2;
            r_q_pc[w_tail_p1] <= r_inflight_pc + 32'd4;
        end
    end

    // Decode-facing view of the two oldest entries, zeroed when not valid.
    always_comb begin
        out_valid1 = (r_count >= CW'(1));
        out_valid2 = (r_count >= CW'(2));
        out_ir1    = 32'h0;
        out_pc1    = 32'h0;
        out_ir2    = 32'h0;
        out_pc2    = 32'h0;
        if (out_valid1) begin
            out_ir1 = r_q_ir[r_head];
            out_pc1 = r_q_pc[r_head];
        end
        if (out_valid2) begin
            out_ir2 = r_q_ir[w_head_p1];
            out_pc2 = r_q_pc[w_head_p1];
        end
        q_count = r_count;
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    // Event counters: issued pairs, stalled cycles, redirects; free-running wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_fetch <= 32'h0;
            r_perf_stall <= 32'h0;
            r_perf_flush <= 32'h0;
        end else begin
            if (w_issue) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (!w_issue && !redirect_valid) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (redirect_valid) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_stall_cnt = r_perf_stall;
    assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plus randomized stimulus for fetch_unit, checked
// each cycle against a queue-based reference model of the fetch pipeline.
module tb_fetch_unit;

    localparam int          QD  = 8;
    localparam logic [31:0] RPC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] imem_addr1;
    logic [12:0] imem_addr2;
    logic [31:0] imem_ir1;
    logic [31:0] imem_ir2;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  deq_count;
    logic        out_valid1;
    logic        out_valid2;
    logic [31:0] out_ir1;
    logic [31:0] out_ir2;
    logic [31:0] out_pc1;
    logic [31:0] out_pc2;
    logic [3:0]  q_count;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.QDEPTH(QD), .RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr1     (imem_addr1),
        .imem_addr2     (imem_addr2),
        .imem_ir1       (imem_ir1),
        .imem_ir2       (imem_ir2),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .deq_count      (deq_count),
        .out_valid1     (out_valid1),
        .out_valid2     (out_valid2),
        .out_ir1        (out_ir1),
        .out_ir2        (out_ir2),
        .out_pc1        (out_pc1),
        .out_pc2        (out_pc2),
        .q_count        (q_count)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    logic [31:0] mem [8192];

    int checks   = 0;
    int failures = 0;
    bit armed    = 0;

    // Reference model: fetch PC, one optional in-flight pair, queue of PCs.
    logic [31:0] m_fpc;
    bit          m_inf;
    logic [31:0] m_ipc;
    logic [31:0] mq [$];
    logic [31:0] m_pf, m_ps, m_pfl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mword(input logic [31:0] pc);
        logic [12:0] ix;
        ix = pc[14:2];
        return mem[ix];
    endfunction

    task automatic check_outputs();
        int          n;
        logic [12:0] f;
        logic [31:0] e_pc1, e_pc2, e_ir1, e_ir2;
        n = mq.size();
        f = m_fpc[14:2];
        e_pc1 = 32'h0; e_pc2 = 32'h0; e_ir1 = 32'h0; e_ir2 = 32'h0;
        if (n >= 1) begin
            e_pc1 = mq[0];
            e_ir1 = mword(e_pc1);
        end
        if (n >= 2) begin
            e_pc2 = mq[1];
            e_ir2 = mword(e_pc2);
        end
        chk("addr1",   {19'b0, imem_addr1}, {19'b0, f});
        chk("addr2",   {19'b0, imem_addr2}, {19'b0, 13'(f + 13'd1)});
        chk("q_count", {28'b0, q_count},    32'(n));
        chk("valid1",  {31'b0, out_valid1}, (n >= 1) ? 32'd1 : 32'd0);
        chk("valid2",  {31'b0, out_valid2}, (n >= 2) ? 32'd1 : 32'd0);
        chk("pc1",     out_pc1, e_pc1);
        chk("pc2",     out_pc2, e_pc2);
        chk("ir1",     out_ir1, e_ir1);
        chk("ir2",     out_ir2, e_ir2);
`ifdef FETCH_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, m_pf);
        chk("perf_stall", perf_stall_cnt, m_ps);
        chk("perf_flush", perf_flush_cnt, m_pfl);
`endif
    endtask

    task automatic model_update(input bit rst, input bit rd, input logic [31:0] rpc,
                                input logic [1:0] dq);
        int used;
        int p;
        bit iss;
        if (rst) begin
            m_fpc = RPC;
            m_inf = 0;
            mq.delete();
            m_pf = 0; m_ps = 0; m_pfl = 0;
        end else if (rd) begin
            mq.delete();
            m_inf = 0;
            m_fpc = rpc;
            m_pfl = m_pfl + 1;
        end else begin
            used = mq.size() + (m_inf ? 2 : 0);
            iss  = (QD - used) >= 2;
            p    = (dq == 2'd3) ? 2 : int'(dq);
            if (p > mq.size()) p = mq.size();
            repeat (p) void'(mq.pop_front());
            if (m_inf) begin
                mq.push_back(m_ipc);
                mq.push_back(m_ipc + 32'd4);
            end
            if (iss) begin
                m_inf = 1;
                m_ipc = m_fpc;
                m_fpc = m_fpc + 32'd8;
                m_pf  = m_pf + 1;
            end else begin
                m_inf = 0;
                m_ps  = m_ps + 1;
            end
        end
    endtask

    // One clock cycle: apply inputs, check, advance model, then clock the DUT
    // and return the memory words for the addresses it presented.
    task automatic cycle(input bit rst, input bit rd, input logic [31:0] rpc,
                         input logic [1:0] dq);
        logic [12:0] a1, a2;
        rst_n          = !rst;
        redirect_valid = rd;
        redirect_pc    = rpc;
        deq_count      = dq;
        if (armed) check_outputs();
        model_update(rst, rd, rpc, dq);
        a1 = imem_addr1;
        a2 = imem_addr2;
        @(posedge clk);
        #1;
        imem_ir1 = mem[a1];
        imem_ir2 = mem[a2];
        armed = 1;
    endtask

    initial begin
        bit          r_rst, r_rd;
        logic [31:0] r_pc;
        logic [1:0]  r_dq;
        for (int i = 0; i < 8192; i++) mem[i] = $urandom;
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; deq_count = 2'd0;
        imem_ir1 = 32'h0; imem_ir2 = 32'h0;
        m_fpc = RPC; m_inf = 0; m_ipc = 32'h0; m_pf = 0; m_ps = 0; m_pfl = 0;

        cycle(1, 0, 32'h0, 2'd0);
        cycle(1, 0, 32'h0, 2'd0);
        // fill from reset until the queue is full and fetch freezes
        repeat (14) cycle(0, 0, 32'h0, 2'd0);
        // sustained drain at two per cycle
        repeat (10) cycle(0, 0, 32'h0, 2'd2);
        // build some occupancy with a read in flight, then redirect to 0x100
        repeat (3) cycle(0, 0, 32'h0, 2'd0);
        cycle(0, 0, 32'h0, 2'd1);
        cycle(0, 1, 32'h100, 2'd0);
        repeat (4) cycle(0, 0, 32'h0, 2'd0);
        // odd occupancy then over-request, and a redirect to the top word
        cycle(0, 0, 32'h0, 2'd1);
        cycle(0, 0, 32'h0, 2'd3);
        cycle(0, 0, 32'h0, 2'd2);
        cycle(0, 1, 32'h7FFC, 2'd0);
        repeat (6) cycle(0, 0, 32'h0, 2'd1);
        // reset mid-stream
        cycle(1, 0, 32'h0, 2'd2);
        repeat (5) cycle(0, 0, 32'h0, 2'd0);
        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            r_rst = ($urandom_range(0, 99) == 0);
            r_rd  = ($urandom_range(0, 15) == 0);
            r_pc  = $urandom & 32'hFFFF_FFFC;
            r_dq  = 2'($urandom_range(0, 3));
            cycle(r_rst, r_rd, r_pc, r_dq);
        end
        cycle(0, 0, 32'h0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
